max_unpool: RTL
===============

Name: max_unpool

Overview:
- Inverse of the 2x2/stride-2 max-pooling stage in the CNN datapath.
- Accepts the n*n pooled results: value, window-position history (0..3) and pooled address.
- Re-expands them into a SIZE*SIZE map in raster order: each pooled value is placed at its recorded argmax position; the other three positions of each window are zero.
- Used on the backward/gradient path and for feature-map reconstruction.

Parameters:
- n, 3: pooled map dimension (n x n); legal range 1..4.
- SIZE, n+n: unpooled map dimension (SIZE x SIZE).
- DW, 16: data width of pooled and unpooled values.

Ports:
- clk  input  1: single clock, rising edge.
- reset  input  1: synchronous reset, active-high.
- en_load  input  1: write one pooled entry this cycle.
- pool_in  input  DW: pooled value to store.
- his_in  input  3: history of pool_in. 0 = (r,c), 1 = (r,c+1), 2 = (r+1,c), 3 = (r+1,c+1) within the window.
- addr_in  input  6: pooled address, row-major (prow*n+pcol).
- en_unpool  input  1: start pulse for the unpool stream.
- out_ready  input  1: downstream accepts the current output beat.
- unpool_out  output  DW: unpooled value.
- out_addr  output  6: unpooled address, r*SIZE+c.
- out_valid  output  1: unpool_out/out_addr are valid.
- done_unpool  output  1: full map streamed.
- err  output  1: sticky error flag; only present when UNPOOL_ERR_EN is defined.

Behaviour:
- Storage: n*n entries of {value[DW-1:0], his[1:0]}.
  - reset clears all entries to 0 and state to IDLE.
  - Outputs in reset: unpool_out=0, out_addr=0, out_valid=0, done_unpool=0, err=0.
- States: IDLE, STREAM, DONE.
- Load (IDLE or DONE):
  - en_load=1 writes entry[addr_in] <= {pool_in, his_in[1:0]} at the clock edge.
  - addr_in >= n*n: write dropped.
  - In DONE, en_load also clears done_unpool and returns to IDLE.
  - Unwritten entries keep their previous contents (0 after reset).
- Start:
  - en_unpool=1 in IDLE or DONE with en_load=0: go to STREAM, r=c=0, done_unpool<=0.
  - en_load and en_unpool in the same cycle: the load is performed and en_unpool is ignored.
- STREAM:
  - out_valid=1; out_addr = r*SIZE+c.
  - Pooled index p = (r>>1)*n + (c>>1); quadrant q = {r[0], c[0]}.
  - unpool_out = entry[p].value if entry[p].his == q, else 0. Combinational from registered r, c and storage.
  - Beat accepted when out_valid && out_ready: c increments; at c=SIZE-1, c<=0 and r increments.
  - out_ready=0: r, c, unpool_out, out_addr held stable.
  - After the beat at out_addr = SIZE*SIZE-1 is accepted: go to DONE.
  - One beat per cycle at best; SIZE*SIZE beats total (36 for n=3).
  - en_load and en_unpool are ignored in STREAM; storage is unchanged.
- DONE:
  - out_valid=0, unpool_out=0, done_unpool=1.
  - Held until en_load or en_unpool.
- When out_valid=0, unpool_out=0 and out_addr=0.
- reset mid-STREAM: next cycle IDLE, out_valid=0, storage cleared.
- Latency: first beat is valid the cycle after the en_unpool edge.

Optional Feature:
- Macro UNPOOL_ERR_EN.
- Defined:
  - Port err exists.
  - err is set sticky when en_load=1 with his_in > 3 or with addr_in >= n*n. The offending write is dropped.
  - err is cleared only by reset.
- Undefined:
  - No err port.
  - his_in[2] is ignored; his_in[1:0] is stored as-is.
  - Out-of-range addresses are silently dropped.

Test Plan:
- Single window:
  - Stimulus: reset; load addr 0 = 0x0010 his 3; en_unpool; out_ready=1.
  - Response: beat at out_addr 7 = 0x0010; out_addr 0, 1 and 6 = 0; every other beat 0; done_unpool=1 after 36 accepted beats.
- Full map:
  - Stimulus: load addr k = 0x0100+k with his = k%4, for k=0..8; stream.
  - Response: addr 8 (his 0) -> out_addr 28 = 0x0108; addr 4 (his 0) -> out_addr 14 = 0x0104; addr 1 (his 1) -> out_addr 3 = 0x0101.
  - Exactly 9 nonzero beats.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles at out_addr 7.
  - Response: out_addr and unpool_out stay 7 / 0x0010; the stream completes with no lost or duplicated address.
- Priority and ignore:
  - Stimulus: en_load and en_unpool together in IDLE.
  - Response: the entry is written; state stays IDLE. en_load during STREAM leaves storage unchanged.
- Reset mid-stream:
  - Stimulus: assert reset at out_addr 20.
  - Response: next cycle out_valid=0; a restarted stream outputs all 0.
- With UNPOOL_ERR_EN:
  - Stimulus: load addr 9 or his 4.
  - Response: err=1 and stays 1; the entry is not written.

Source files
------------

// File: rtl/max_unpool.sv
// max_unpool: inverse of the 2x2/stride-2 max-pooling stage.
// Stores n*n pooled entries {value, window position} and streams them back out
// as a SIZE x SIZE raster map. Each value lands at its recorded argmax position,
// and the other three positions of its window read as zero.
// Optional feature: define UNPOOL_ERR_EN to add a sticky err output. The flag
// reports a load with his_in > 3 or with addr_in >= n*n.
module max_unpool #(
   parameter int n    = 3,
   parameter int SIZE = n + n,
   parameter int DW   = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en_load,
   input  logic [DW-1:0] pool_in,
   input  logic [2:0]    his_in,
   input  logic [5:0]    addr_in,
   input  logic          en_unpool,
   input  logic          out_ready,
   output logic [DW-1:0] unpool_out,
   output logic [5:0]    out_addr,
   output logic          out_valid,
   output logic          done_unpool
`ifdef UNPOOL_ERR_EN
   ,
   output logic          err
`endif
);

   localparam int         N_ENT = n * n;
   localparam int         IW    = (N_ENT > 1) ? $clog2(N_ENT) : 1;
   localparam logic [2:0] LAST  = 3'(SIZE - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

   state_e          state_q, state_d;
   logic [2:0]      r_q, r_d;
   logic [2:0]      c_q, c_d;
   logic [DW-1:0]   val_q [N_ENT];
   logic [DW-1:0]   val_d [N_ENT];
   logic [1:0]      his_q [N_ENT];
   logic [1:0]      his_d [N_ENT];

   logic            load_cmd;
   logic            addr_ok;
   logic            his_ok;
   logic            wr_en;
   logic [IW-1:0]   wr_idx;
   logic [IW-1:0]   p_idx;
   logic [1:0]      quad;

`ifdef UNPOOL_ERR_EN
   logic            err_q, err_d;
`else
   logic            unused_his;
   // Without error reporting, his_in[2] carries no meaning and is ignored.
   assign unused_his = his_in[2];
`endif

   // Load qualification: loads are accepted only outside STREAM and only for in-range addresses.
   always_comb begin
      load_cmd = en_load && (state_q != STREAM);
      addr_ok  = addr_in < 6'(N_ENT);
`ifdef UNPOOL_ERR_EN
      his_ok   = !his_in[2];
      err_d    = err_q | (load_cmd && (!addr_ok || !his_ok));
`else
      his_ok   = 1'b1;
`endif
      wr_en    = load_cmd && addr_ok && his_ok;
      wr_idx   = IW'(addr_in);
   end

   // Storage update: copy the current contents, then overwrite the addressed entry.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
      val_d = val_q;
      his_d = his_q;
      if (wr_en) begin
         val_d[wr_idx] = pool_in;
         his_d[wr_idx] = his_in[1:0];
      end
   end

   // Next-state and raster position logic.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
      case (state_q)
         IDLE, DONE: begin
            // A load wins over a start request in the same cycle.
            if (en_load) begin
               state_d = IDLE;
            end else if (en_unpool) begin
               state_d = STREAM;
               r_d     = '0;
               c_d     = '0;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (c_q == LAST) begin
                  c_d = '0;
                  if (r_q == LAST) state_d = DONE;
                  else             r_d     = r_q + 3'd1;
               end else begin
                  c_d = c_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, position and storage registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so that every flop samples the pre-edge values.
      if (reset) begin
         state_q <= IDLE;
         r_q     <= '0;
         c_q     <= '0;
         // NOTE: storage is explicitly cleared on reset because an unwritten window must unpool to zeros.
         // This keeps the storage as resettable flops and stops it from being inferred as a RAM.
         for (int i = 0; i < N_ENT; i++) begin
            val_q[i] <= '0;
            his_q[i] <= '0;
         end
`ifdef UNPOOL_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         c_q     <= c_d;
         val_q   <= val_d;
         his_q   <= his_d;
`ifdef UNPOOL_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   // Output decode: the unpooled value is a lookup from the registered position and the storage.
   always_comb begin
      unpool_out  = '0;
      out_addr    = '0;
      out_valid   = 1'b0;
      done_unpool = 1'b0;
      p_idx       = IW'(int'(r_q >> 1) * n + int'(c_q >> 1));
      quad        = {r_q[0], c_q[0]};
      case (state_q)
         STREAM: begin
            out_valid = 1'b1;
            out_addr  = 6'(int'(r_q) * SIZE + int'(c_q));
            if (his_q[p_idx] == quad) unpool_out = val_q[p_idx];
         end
         DONE:    done_unpool = 1'b1;
         default: ;
      endcase
   end

`ifdef UNPOOL_ERR_EN
   assign err = err_q;
`endif

endmodule
